ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
Second-generation PS/2 keyboard receiver, running entirely in the system clock domain. It synchronises and glitch-filters psClk/psData and frames each 11-bit packet with odd-parity and stop-bit checks plus an inter-bit timeout. It decodes the E0 (extended) and F0 (break) prefixes into make/break key events and buffers those events in a parametrised FIFO with a valid/ready handshake. It feeds the controller-input logic in place of a single "current key" register, so no key transition is lost.

Parameters:
SYNC_STAGES, 2, flip-flop stages on psClk and psData (minimum 2)
FILTER_LEN, 8, consecutive identical samples needed before a filtered line changes (minimum 1)
TIMEOUT_CYCLES, 50000, Clk cycles allowed between falling edges inside a frame before abort
FIFO_DEPTH, 8, event FIFO entries (power of 2, minimum 2)

Ports:
Clk  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
psClk  input  1  raw PS/2 clock pin, asynchronous
psData  input  1  raw PS/2 data pin, asynchronous
evt_valid  output  1  FIFO head is valid
evt_ready  input  1  consumer accepts head this cycle
evt_code  output  8  scan code of the head event
evt_ext  output  1  head event was E0-prefixed
evt_break  output  1  1 = key released, 0 = key pressed
frame_err  output  1  one-cycle pulse: parity error, stop-bit error or timeout
overflow  output  1  one-cycle pulse: event dropped because the FIFO was full
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored events

Behaviour:
- Reset (asynchronous, reset_n=0): synchroniser and filter outputs = 1 (idle bus); FSM = IDLE; ext/brk prefix flags = 0; FIFO empty; all outputs = 0.
- Filter: each filtered line takes the synchronised value once FILTER_LEN consecutive equal samples are seen. fall = filtered clock 1->0, registered as a one-cycle pulse. Data is sampled from the filtered data line in the same cycle as fall.
- FSM: IDLE, DATA, PARITY, STOP. Only a fall pulse advances it.
  - IDLE: data=0 -> DATA with bit counter = 0. data=1 -> stay in IDLE, no error.
  - DATA: shift bits in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the bit; parity is good when XOR(data[7:0], parity bit) = 1 -> STOP.
  - STOP: data=1 and parity good -> byte_vld pulse on the next cycle. Otherwise frame_err pulse and the byte is discarded. Either way -> IDLE.
- Timeout: a counter clears on every fall and counts while the FSM is not IDLE. When it reaches TIMEOUT_CYCLES: -> IDLE, frame_err pulse, prefix flags cleared. The counter is held at 0 in IDLE.
- Decoder, on byte_vld:
  - 8'hE0: set ext, no push.
  - 8'hF0: set brk, no push.
  - Any other byte: push {ext, brk, byte}, then clear both flags.
  - Bytes E1, AA, FA, FE are ordinary codes.
  - A frame_err does not clear the flags; a timeout does.
- FIFO: show-ahead; evt_* reflect the head whenever evt_valid=1 and hold stable until popped. Pop happens when evt_valid && evt_ready.
  - Push while full with no pop: event dropped, overflow pulses, contents unchanged.
  - Push and pop together while full: both occur, count unchanged, no overflow.
  - Push and pop together while empty: not possible, because evt_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: let F = the cycle the STOP-bit fall pulse is high. byte_vld is high at F+1, the push occurs at the end of F+1, and evt_valid rises at F+2 if the FIFO was empty.
- evt_ready is ignored while evt_valid=0.
- Reset mid-frame aborts immediately. No partial event is produced after reset_n is released.

Decomposition:
- Package ps2_pkg holds:
  - state enum ps2_state_t {IDLE, DATA, PARITY, STOP}
  - localparams PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0
  - packed struct ps2_evt_t {ext, brk, code[7:0]}
- Sub-module ps2_event_fifo: FIFO_DEPTH-parameterised, ps2_evt_t payload, valid/ready output, count and overflow.
- Synchroniser, filter, FSM and decoder stay in ps2_keyboard_rx.

Test Plan:
- Send frame 8'h1C (parity 0, stop 1) with evt_ready=1 -> exactly one event {code=1C, ext=0, break=0}, evt_valid rises 2 cycles after the stop fall.
- Send F0,1C then E0,75 then E0,F0,75 -> events {1C,ext0,brk1}, {75,ext1,brk0}, {75,ext1,brk1}, in that order.
- Send 8'h1C with parity forced to 1 -> frame_err pulses once, no event, fifo_count = 0. A following good 8'h1C is received normally.
- Send 5 bits of a frame, then idle for TIMEOUT_CYCLES+10 -> frame_err at timeout, FSM back in IDLE. A following good 8'h23 yields event 23.
- Hold evt_ready=0 and send FIFO_DEPTH+1 codes (0x01..0x09 at depth 8) -> fifo_count = 8, one overflow pulse. Drain yields 01..08; 09 is lost.
- Inject 2-cycle glitches on psClk (< FILTER_LEN) mid-frame -> no extra bit, and the correct code is received. Assert reset_n=0 mid-frame -> all outputs 0 immediately and no spurious event afterwards.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and prefix codes for the PS/2 keyboard receiver
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: show-ahead key-event FIFO with valid/ready output and overflow pulse
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  ps2_evt_t               data_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output ps2_evt_t               data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   overflow_o
);
   localparam int AW = $clog2(DEPTH);
   ps2_evt_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [AW:0]     count_q;
   logic            ovf_q, pop, full, wr;
   assign valid_o    = count_q != '0;
   assign pop        = valid_o & ready_i;
   assign full       = count_q == (AW+1)'(DEPTH);
   // a pop frees the slot in the same cycle, so a full FIFO still accepts
   assign wr         = push_i & (~full | pop);
   assign data_o     = mem_q[rd_q];
   assign count_o    = count_q;
   assign overflow_o = ovf_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (wr) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop) rd_q <= rd_q + AW'(1);
         count_q <= count_q + (AW+1)'(wr) - (AW+1)'(pop);
         ovf_q   <= push_i & full & ~pop;
      end
   end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: filtered PS/2 frame receiver decoding E0/F0 prefixes into buffered key events
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                        Clk,
   input  logic                        reset_n,
   input  logic                        psClk,
   input  logic                        psData,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [7:0]                  evt_code,
   output logic                        evt_ext,
   output logic                        evt_break,
   output logic                        frame_err,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
   logic [1:0]             raw, flt_q, flt_d;
   logic [FW-1:0]          fcnt_q [2];
   logic [FW-1:0]          fcnt_d [2];
   logic                   fall_q;
   ps2_state_t             state_q;
   logic [2:0]             bit_cnt_q;
   logic [7:0]             shift_q;
   logic                   par_ok_q, byte_vld_q, frame_err_q, ext_q, brk_q;
   logic [TW-1:0]          to_cnt_q;
   logic                   timeout, push;
   ps2_evt_t               head;
   assign raw = {dat_sync_q[SYNC_STAGES-1], clk_sync_q[SYNC_STAGES-1]};
   // index 0 is the clock line, index 1 the data line
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         flt_d[i]  = flt_q[i];
         fcnt_d[i] = '0;
         if (raw[i] != flt_q[i]) begin
            if (fcnt_q[i] == FW'(FILTER_LEN - 1)) flt_d[i] = raw[i];
            else fcnt_d[i] = fcnt_q[i] + FW'(1);
         end
      end
   end
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         flt_q      <= '1;
         fcnt_q     <= '{default: '0};
         fall_q     <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], psClk};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], psData};
         flt_q      <= flt_d;
         fcnt_q     <= fcnt_d;
         fall_q     <= flt_q[0] & ~flt_d[0];
      end
   end
   assign timeout = state_q != IDLE && !fall_q && to_cnt_q == TW'(TIMEOUT_CYCLES);
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_ok_q    <= 1'b0;
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
         to_cnt_q    <= '0;
      end else begin
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
         to_cnt_q    <= (state_q == IDLE || fall_q || timeout) ? '0 : to_cnt_q + TW'(1);
         if (timeout) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
         end else if (fall_q) begin
            case (state_q)
               IDLE: if (!flt_q[1]) begin
                  state_q   <= DATA;
                  bit_cnt_q <= '0;
               end
               DATA: begin
                  shift_q   <= {flt_q[1], shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  par_ok_q <= ^shift_q ^ flt_q[1];
                  state_q  <= STOP;
               end
               default: begin
                  byte_vld_q  <= flt_q[1] & par_ok_q;
                  frame_err_q <= ~(flt_q[1] & par_ok_q);
                  state_q     <= IDLE;
               end
            endcase
         end
      end
   end
   assign push = byte_vld_q && shift_q != PS2_EXT && shift_q != PS2_BRK;
   // prefixes survive a bad frame but not a timeout
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (timeout || push) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (byte_vld_q) begin
         ext_q <= ext_q | (shift_q == PS2_EXT);
         brk_q <= brk_q | (shift_q == PS2_BRK);
      end
   end
   ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (Clk),
      .rst_ni     (reset_n),
      .push_i     (push),
      .data_i     ('{ext: ext_q, brk: brk_q, code: shift_q}),
      .valid_o    (evt_valid),
      .ready_i    (evt_ready),
      .data_o     (head),
      .count_o    (fifo_count),
      .overflow_o (overflow)
   );
   assign evt_code  = head.code;
   assign evt_ext   = head.ext;
   assign evt_break = head.brk;
   assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: frame-level scoreboard bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
   localparam int SS = 2, FL = 8, TO = 300, FD = 8, H = 20;
   logic       Clk = 1'b0, reset_n, psClk, psData, evt_ready;
   logic       evt_valid, evt_ext, evt_break, frame_err, overflow;
   logic [7:0] evt_code;
   logic [3:0] fifo_count;
   int         n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0, lat = -1;
   int         ferr_cnt = 0, ovf_cnt = 0, exp_ferr = 0, exp_ovf = 0;
   logic [9:0] exp_q[$];
   logic [9:0] got[$];
   logic       mext = 1'b0, mbrk = 1'b0, prev_valid = 1'b0;

   ps2_keyboard_rx #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)) dut (
      .Clk(Clk), .reset_n(reset_n), .psClk(psClk), .psData(psData),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_ext(evt_ext), .evt_break(evt_break), .frame_err(frame_err),
      .overflow(overflow), .fifo_count(fifo_count));

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // model of the decoder: what a correctly received byte means
   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) mext = 1'b1;
      else if (b == 8'hF0) mbrk = 1'b1;
      else begin
         if (!evt_ready && exp_q.size() >= FD) exp_ovf++;
         else exp_q.push_back({mext, mbrk, b});
         mext = 1'b0;
         mbrk = 1'b0;
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, input bit bad_par, input bit bad_stop, input int gl);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < n; i++) begin
         psData = bits[i];
         if (i == gl) begin
            cyc_wait(H/2); psClk = 1'b0; cyc_wait(2); psClk = 1'b1; cyc_wait(H/2 - 2);
         end else cyc_wait(H);
         psClk = 1'b0;
         if (i == 10) begin
            t0 = cyc;
            if (bad_par || bad_stop) exp_ferr++;
            else model_byte(b);
         end
         if (i == gl) begin
            cyc_wait(H/2); psClk = 1'b1; cyc_wait(2); psClk = 1'b0; cyc_wait(H/2 - 2);
         end else cyc_wait(H);
         psClk = 1'b1;
      end
      psData = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0, input int gl = -1);
      send_bits(b, 11, bad_par, bad_stop, gl);
      cyc_wait(2*H);
   endtask

   always @(negedge Clk) begin
      if (reset_n) begin
         if (frame_err) ferr_cnt++;
         if (overflow) ovf_cnt++;
         if (evt_valid && !prev_valid) lat = cyc - t0;
         if (evt_valid) begin
            if (exp_q.size() == 0) chk("spurious_evt", {22'd0, evt_ext, evt_break, evt_code}, 32'hFFFF_FFFF);
            else begin
               chk("evt_code", evt_code, exp_q[0][7:0]);
               chk("evt_ext", evt_ext, exp_q[0][9]);
               chk("evt_break", evt_break, exp_q[0][8]);
               if (evt_ready) begin
                  void'(exp_q.pop_front());
                  got.push_back({evt_ext, evt_break, evt_code});
               end
            end
         end
      end
      prev_valid = evt_valid;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; psClk = 1'b1; psData = 1'b1; evt_ready = 1'b1;
      cyc_wait(3);
      chk("rst_valid", evt_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_code", {evt_ext, evt_break, evt_code}, 0);
      chk("rst_pulses", {frame_err, overflow}, 0);
      reset_n = 1'b1;
      cyc_wait(5);

      got.delete();
      send_frame(8'h1C);
      chk("t1_n", got.size(), 1);
      chk("t1_evt", got[0], 10'h01C);
      chk("t1_latency", lat, SS + FL + 2);

      got.delete();
      send_frame(8'hF0); send_frame(8'h1C);
      send_frame(8'hE0); send_frame(8'h75);
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
      chk("t2_n", got.size(), 3);
      chk("t2_evt0", got[0], 10'h11C);
      chk("t2_evt1", got[1], 10'h275);
      chk("t2_evt2", got[2], 10'h375);

      got.delete();
      send_frame(8'h1C, 1'b1);
      chk("t3_ferr", ferr_cnt, 1);
      chk("t3_count", fifo_count, 0);
      send_frame(8'h1C);
      send_frame(8'hE0); send_frame(8'h1C, 1'b1); send_frame(8'h1C);
      send_frame(8'h33, 1'b0, 1'b1);
      send_frame(8'hE1); send_frame(8'hAA); send_frame(8'hFA); send_frame(8'hFE);
      chk("t3_ferr_all", ferr_cnt, exp_ferr);
      chk("t3_n", got.size(), 6);
      chk("t3_evt0", got[0], 10'h01C);
      chk("t3_evt1", got[1], 10'h21C);
      chk("t3_evt5", got[5], 10'h0FE);

      got.delete();
      send_frame(8'hF0);
      send_bits(8'h23, 5, 1'b0, 1'b0, -1);
      exp_ferr++; mext = 1'b0; mbrk = 1'b0;
      cyc_wait(TO + 40);
      chk("t4_timeout", ferr_cnt, exp_ferr);
      send_frame(8'h23);
      chk("t4_n", got.size(), 1);
      chk("t4_evt", got[0], 10'h023);

      got.delete();
      evt_ready = 1'b0;
      for (int i = 1; i <= FD + 1; i++) send_frame(8'(i));
      chk("t5_count", fifo_count, FD);
      chk("t5_ovf", ovf_cnt, 1);
      evt_ready = 1'b1;
      cyc_wait(20);
      chk("t5_drained", fifo_count, 0);
      chk("t5_n", got.size(), FD);
      for (int i = 0; i < FD; i++) chk("t5_evt", got[i], 32'(i + 1));

      got.delete();
      send_frame(8'h5A, 1'b0, 1'b0, 3);
      send_frame(8'h3C, 1'b0, 1'b0, 9);
      chk("t6_n", got.size(), 2);
      chk("t6_evt0", got[0], 10'h05A);
      chk("t6_evt1", got[1], 10'h03C);

      got.delete();
      evt_ready = 1'b0;
      send_frame(8'h1C);
      chk("t7_held", fifo_count, 1);
      send_bits(8'h5A, 4, 1'b0, 1'b0, -1);
      psClk = 1'b0;
      cyc_wait(3);
      reset_n = 1'b0;
      #1;
      chk("t7_valid", evt_valid, 0);
      chk("t7_count", fifo_count, 0);
      chk("t7_code", {evt_ext, evt_break, evt_code}, 0);
      chk("t7_pulses", {frame_err, overflow}, 0);
      exp_q.delete(); mext = 1'b0; mbrk = 1'b0;
      psClk = 1'b1; psData = 1'b1;
      cyc_wait(3);
      reset_n = 1'b1;
      cyc_wait(TO + 100);
      chk("t7_no_evt", fifo_count, 0);
      chk("t7_no_err", ferr_cnt, exp_ferr);
      evt_ready = 1'b1;
      send_frame(8'h1C);
      chk("t7_n", got.size(), 1);
      chk("t7_evt", got[0], 10'h01C);

      chk("end_queue", exp_q.size(), 0);
      chk("end_ferr", ferr_cnt, exp_ferr);
      chk("end_ovf", ovf_cnt, exp_ovf);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
